// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and issue-check: accepts up to IN_W
// (pc, inst) pairs per cycle and presents up to OUT_W oldest entries in program order.
module fetch_queue #(
    parameter int PC_W   = 13,
    parameter int INST_W = 32,
    parameter int DEPTH  = 8,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [$clog2(IN_W+1)-1:0]    push_cnt,
    input  logic [IN_W*PC_W-1:0]         pc_in,
    input  logic [IN_W*INST_W-1:0]       inst_in,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [$clog2(OUT_W+1)-1:0]   out_cnt,
    output logic [OUT_W*PC_W-1:0]        pc_out,
    output logic [OUT_W*INST_W-1:0]      inst_out,
    input  logic [$clog2(OUT_W+1)-1:0]   pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int PUSH_W = $clog2(IN_W+1);
    localparam int POP_W  = $clog2(OUT_W+1);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PUSH_W-1:0] push_lim;
    logic [PUSH_W-1:0] push_acc;
    logic [POP_W-1:0]  pop_eff;

    // Readiness looks only at the registered count; a same-cycle pop never raises it.
    assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_W);
    assign count    = count_q;

    assign out_cnt  = (count_q >= CNT_W'(OUT_W)) ? POP_W'(OUT_W) : POP_W'(count_q);
    assign push_lim = (push_cnt > PUSH_W'(IN_W)) ? PUSH_W'(IN_W) : push_cnt;
    assign push_acc = (in_ready && !flush) ? push_lim : '0;
    assign pop_eff  = (pop_cnt > out_cnt) ? out_cnt : pop_cnt;

    always_comb begin
        head_d  = head_q + PTR_W'(pop_eff);
        tail_d  = tail_q + PTR_W'(push_acc);
        count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_eff);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; lanes beyond out_cnt are masked,
    // so stale contents are never observable.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < IN_W; k++) begin
            if (PUSH_W'(k) < push_acc) begin
                pc_mem[tail_q + PTR_W'(k)]   <= pc_in[k*PC_W +: PC_W];
                inst_mem[tail_q + PTR_W'(k)] <= inst_in[k*INST_W +: INST_W];
            end
        end
    end

    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    always_comb begin
        pc_out   = '0;
        inst_out = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (POP_W'(k) < out_cnt) begin
                pc_out[k*PC_W +: PC_W]       = pc_mem[head_q + PTR_W'(k)];
                inst_out[k*INST_W +: INST_W] = inst_mem[head_q + PTR_W'(k)];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model predicts the
// post-edge outputs, a separate monitor compares them against the DUT.
module tb_fetch_queue;

    localparam int PC_W   = 13;
    localparam int INST_W = 32;
    localparam int DEPTH  = 8;
    localparam int IN_W   = 2;
    localparam int OUT_W  = 2;
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int PUSH_W = $clog2(IN_W+1);
    localparam int POP_W  = $clog2(OUT_W+1);

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    typedef struct {
        int                      cnt;
        int                      ocnt;
        bit                      rdy;
        logic [OUT_W*PC_W-1:0]   pcs;
        logic [OUT_W*INST_W-1:0] insts;
    } snap_t;

    logic                       CLK = 1'b0;
    logic                       RST = 1'b1;
    logic [PUSH_W-1:0]          push_cnt = '0;
    logic [IN_W*PC_W-1:0]       pc_in = '0;
    logic [IN_W*INST_W-1:0]     inst_in = '0;
    logic                       in_ready;
    logic                       flush = 1'b0;
    logic [POP_W-1:0]           out_cnt;
    logic [OUT_W*PC_W-1:0]      pc_out;
    logic [OUT_W*INST_W-1:0]    inst_out;
    logic [POP_W-1:0]           pop_cnt = '0;
    logic [CNT_W-1:0]           count;

    int n_cmp = 0;
    int n_err = 0;

    entry_t model_q[$];
    snap_t  exp_q[$];

    fetch_queue #(
        .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .push_cnt (push_cnt),
        .pc_in    (pc_in),
        .inst_in  (inst_in),
        .in_ready (in_ready),
        .flush    (flush),
        .out_cnt  (out_cnt),
        .pc_out   (pc_out),
        .inst_out (inst_out),
        .pop_cnt  (pop_cnt),
        .count    (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected visible outputs derived from the model contents alone.
    function automatic snap_t model_snap();
        snap_t s;
        s.cnt   = model_q.size();
        s.ocnt  = min2(model_q.size(), OUT_W);
        s.rdy   = (DEPTH - model_q.size()) >= IN_W;
        s.pcs   = '0;
        s.insts = '0;
        for (int k = 0; k < s.ocnt; k++) begin
            s.pcs[k*PC_W +: PC_W]       = model_q[k].pc;
            s.insts[k*INST_W +: INST_W] = model_q[k].inst;
        end
        return s;
    endfunction

    // One clock cycle of stimulus; lane k carries pc0 + 4*k.
    task automatic cycle(input int pn, input logic [PC_W-1:0] pc0, input int pp, input bit fl);
        entry_t e [IN_W];
        int     pre_size;
        bit     ready;
        @(negedge CLK);
        for (int k = 0; k < IN_W; k++) begin
            e[k].pc   = pc0 + PC_W'(4 * k);
            e[k].inst = $urandom;
            pc_in[k*PC_W +: PC_W]       = e[k].pc;
            inst_in[k*INST_W +: INST_W] = e[k].inst;
        end
        push_cnt = PUSH_W'(pn);
        pop_cnt  = POP_W'(pp);
        flush    = fl;

        pre_size = model_q.size();
        ready    = (DEPTH - pre_size) >= IN_W;
        if (fl) begin
            model_q.delete();
        end else begin
            repeat (min2(pp, min2(pre_size, OUT_W))) void'(model_q.pop_front());
            if (ready)
                for (int k = 0; k < pn; k++) model_q.push_back(e[k]);
        end
        exp_q.push_back(model_snap());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".count"},    128'(count),    128'(0));
        check({tag, ".out_cnt"},  128'(out_cnt),  128'(0));
        check({tag, ".pc_out"},   128'(pc_out),   128'(0));
        check({tag, ".inst_out"}, 128'(inst_out), 128'(0));
        check({tag, ".in_ready"}, 128'(in_ready), 128'(1));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
    task automatic mid_reset();
        @(negedge CLK);
        push_cnt = '0;
        pop_cnt  = '0;
        flush    = 1'b0;
        #1 RST = 1'b1;
        #1 check_reset_outputs("mid_reset");
        model_q.delete();
        @(negedge CLK);
        #2 RST = 1'b0;
    endtask

    // Monitor: compares the DUT against each predicted snapshot just after the edge.
    initial begin
        snap_t s;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("count",    128'(count),    128'(s.cnt));
                check("out_cnt",  128'(out_cnt),  128'(s.ocnt));
                check("in_ready", 128'(in_ready), 128'(s.rdy));
                check("pc_out",   128'(pc_out),   128'(s.pcs));
                check("inst_out", 128'(inst_out), 128'(s.insts));
            end
        end
    end

    initial begin
        int wait_cycles;

        // Reset held: outputs zero, in_ready high.
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        #2 RST = 1'b0;

        // First group, then fill to full and attempt an ignored fifth push.
        cycle(2, 13'h000, 0, 1'b0);
        cycle(2, 13'h008, 0, 1'b0);
        cycle(2, 13'h010, 0, 1'b0);
        cycle(2, 13'h018, 0, 1'b0);
        cycle(2, 13'h020, 0, 1'b0);
        // Full with simultaneous push and pop: push refused, then accepted.
        cycle(2, 13'h020, 2, 1'b0);
        cycle(2, 13'h020, 0, 1'b0);

        // Wrap case: head lands on 7 holding 0x01C, 0x020, 0x024.
        cycle(0, 13'h000, 0, 1'b1);
        cycle(2, 13'h000, 0, 1'b0);
        cycle(2, 13'h008, 0, 1'b0);
        cycle(2, 13'h010, 0, 1'b0);
        cycle(2, 13'h018, 0, 1'b0);
        cycle(0, 13'h000, 2, 1'b0);
        cycle(0, 13'h000, 2, 1'b0);
        cycle(0, 13'h000, 2, 1'b0);
        cycle(2, 13'h020, 1, 1'b0);
        cycle(0, 13'h000, 2, 1'b0);
        // Over-pop with a single entry left.
        cycle(0, 13'h000, 2, 1'b0);
        cycle(0, 13'h000, 0, 1'b0);

        // Flush at count 5 with concurrent push and pop, then a fresh push.
        cycle(2, 13'h040, 0, 1'b0);
        cycle(2, 13'h048, 0, 1'b0);
        cycle(1, 13'h050, 0, 1'b0);
        cycle(2, 13'h058, 1, 1'b1);
        cycle(2, 13'h100, 0, 1'b0);
        cycle(0, 13'h000, 0, 1'b0);

        // Randomised traffic with a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            cycle(int'($urandom_range(0, IN_W)), PC_W'($urandom), int'($urandom_range(0, OUT_W)),
                  ($urandom_range(0, 99) < 3));
        end

        cycle(0, 13'h000, 0, 1'b0);
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge CLK);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
